// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the instruction-fetch stage.
//   fetch_state_e : fetch FSM state (ISSUE / WAIT / DRAIN), 2 bits
//   NOP_INSTR     : bubble instruction (sll $0,$0,0)
//   fetch_pkt_t   : one fetched instruction together with its address
package mips_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,   // free to send a request
        WAIT  = 2'd1,   // one live request outstanding
        DRAIN = 2'd2    // request outstanding but killed by a flush
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding register for a fetched packet.
//   clk      : clock, rising edge
//   rst_ni   : asynchronous active-low reset (buffer empty)
//   clear_i  : drop any held packet (highest priority)
//   load_i   : capture pkt_i, buffer becomes full
//   unload_i : release the held packet, buffer becomes empty
//   pkt_i    : packet to capture
//   full_o   : buffer holds a packet
//   pkt_o    : held packet
module if_skid_buf
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       unload_i,
    input  fetch_pkt_t pkt_i,
    output logic       full_o,
    output fetch_pkt_t pkt_o
);

    logic       full_q, full_d;
    fetch_pkt_t pkt_q, pkt_d;

    always_comb begin
        full_d = full_q;
        pkt_d  = pkt_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            pkt_d  = pkt_i;
        end else if (unload_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            pkt_q  <= '0;
        end else begin
            full_q <= full_d;
            pkt_q  <= pkt_d;
        end
    end

    assign full_o = full_q;
    assign pkt_o  = pkt_q;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch between the PC register and IF/ID.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   pc          : current PC;  pc_we : 1 = PC may advance/redirect, 0 = hold
//   flush       : redirect from EX, kills the fetch in flight
//   stall_id    : decode stall, IF/ID must hold
//   imem_req/imem_addr/imem_rvalid/imem_rdata : instruction memory port,
//                 at most one request outstanding
//   ifid_valid/ifid_instr/ifid_pc/ifid_pc4    : IF/ID pipeline register
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_we,
    input  logic        flush,
    input  logic        stall_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;

    logic         req, we, deliver;
    logic         skid_full, skid_load, skid_unload;
    fetch_pkt_t   skid_pkt, deliver_pkt;

    logic         unused_pc_lsb;
    assign unused_pc_lsb = ^pc[1:0];

    assign imem_addr = {pc[31:2], 2'b00};

    // A response is only meaningful for a live request; in DRAIN it is the
    // killed request's data and in ISSUE it is a protocol error.
    assign deliver     = (state_q == WAIT) && imem_rvalid && !flush;
    assign deliver_pkt = '{instr: imem_rdata, pc: req_pc_q};

    // The skid entry leaves in any cycle decode is not stalled, so a new
    // request may go out alongside the unload; while it stays put, issuing
    // would risk a second packet with nowhere to land.
    assign skid_load   = deliver && stall_id;
    assign skid_unload = skid_full && !stall_id && !flush;

    always_comb begin
        req      = 1'b0;
        we       = 1'b0;
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            ISSUE: begin
                req = !(skid_full && stall_id) && !flush;
                we  = req || flush;
                if (req) begin
                    state_d  = WAIT;
                    req_pc_d = imem_addr;
                end
            end
            WAIT: begin
                we = flush;
                if (imem_rvalid)
                    state_d = ISSUE;
                else if (flush)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (imem_rvalid)
                    state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    // Requests and PC writes are forced off for as long as reset is held.
    assign imem_req = rst && req;
    assign pc_we    = rst && we;

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!stall_id) begin
            if (skid_full) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = skid_pkt.instr;
                ifid_pc_d    = skid_pkt.pc;
            end else if (deliver) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = deliver_pkt.instr;
                ifid_pc_d    = deliver_pkt.pc;
            end else begin
                // Bubble: the PC fields keep the last real address.
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ISSUE;
            req_pc_q     <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    if_skid_buf u_skid (
        .clk      (clk),
        .rst_ni   (rst),
        .clear_i  (flush),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .pkt_i    (deliver_pkt),
        .full_o   (skid_full),
        .pkt_o    (skid_pkt)
    );

    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc_q + 32'd4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench for if_fetch_stage. Models the upstream
// PC register and a fixed-latency instruction memory, tracks the expected
// stage behaviour transactionally (in-flight request, skid queue, IF/ID
// contents) and compares every output on every cycle, plus literal pins.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] MEM_BASE = 32'h2008_0005;

    logic        clk = 1'b0;
    logic        rst, flush, stall_id, imem_rvalid;
    logic [31:0] pc, imem_rdata;
    logic        pc_we, imem_req, ifid_valid;
    logic [31:0] imem_addr, ifid_instr, ifid_pc, ifid_pc4;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_we       (pc_we),
        .flush       (flush),
        .stall_id    (stall_id),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Environment: redirect target and memory latency for the next request.
    logic [31:0] target;
    int          lat;
    logic        resp_pend;
    int          resp_cnt;
    logic [31:0] resp_addr;

    // Model: in-flight request, skid contents, IF/ID contents.
    logic        m_out, m_killed;
    logic [31:0] m_out_pc;
    logic [63:0] m_skid[$];
    logic        m_valid;
    logic [31:0] m_instr, m_pc;

    // Snapshot of DUT outputs from the most recent tick (for literal pins).
    logic        s_req, s_we, s_valid;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out   = 1'b0;
        m_killed = 1'b0;
        m_out_pc = 32'h0;
        m_skid.delete();
        m_valid = 1'b0;
        m_instr = NOP;
        m_pc    = RST_PC;
    endtask

    task automatic tick();
        logic        e_req, e_we, dlv;
        logic [63:0] pkt;
        logic [31:0] pc_next;
        @(negedge clk);
        s_req = imem_req; s_we = pc_we; s_valid = ifid_valid; s_addr = imem_addr;
        s_instr = ifid_instr; s_pc = ifid_pc; s_pc4 = ifid_pc4;
        if (!rst) model_reset();
        if (!rst) begin
            e_req = 1'b0; e_we = 1'b0;
        end else if (!m_out) begin
            e_req = !flush && !(m_skid.size() != 0 && stall_id);
            e_we  = e_req || flush;
        end else begin
            e_req = 1'b0;
            e_we  = !m_killed && flush;
        end
        chk("imem_req", imem_req, e_req);
        chk("pc_we", pc_we, e_we);
        if (e_req) chk("imem_addr", imem_addr, {pc[31:2], 2'b00});
        chk("ifid_valid", ifid_valid, m_valid);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc", ifid_pc, m_pc);
        chk("ifid_pc4", ifid_pc4, m_pc + 32'd4);
        if (rst) begin
            dlv = m_out && !m_killed && imem_rvalid && !flush;
            if (flush) begin
                m_valid = 1'b0; m_instr = NOP; m_skid.delete();
            end else if (stall_id) begin
                if (dlv) m_skid.push_back({imem_rdata, m_out_pc});
            end else if (m_skid.size() != 0) begin
                pkt = m_skid.pop_front();
                m_valid = 1'b1; m_instr = pkt[63:32]; m_pc = pkt[31:0];
            end else if (dlv) begin
                m_valid = 1'b1; m_instr = imem_rdata; m_pc = m_out_pc;
            end else begin
                m_valid = 1'b0; m_instr = NOP;
            end
            if (m_out) begin
                if (imem_rvalid) m_out = 1'b0;
                else if (flush) m_killed = 1'b1;
            end else if (e_req) begin
                m_out = 1'b1; m_killed = 1'b0; m_out_pc = {pc[31:2], 2'b00};
            end
            if (imem_req) begin
                resp_pend = 1'b1; resp_cnt = lat; resp_addr = imem_addr;
            end
        end
        pc_next = !rst ? RST_PC : (pc_we ? (flush ? target : pc + 32'd4) : pc);
        @(posedge clk);
        #1;
        pc = pc_next;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (resp_pend) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = MEM_BASE ^ resp_addr;
                resp_pend   = 1'b0;
            end
        end
        cyc++;
    endtask

    initial begin
        bit found;
        rst = 1'b1; flush = 1'b0; stall_id = 1'b0; pc = RST_PC;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; target = 32'h0; lat = 1;
        resp_pend = 1'b0; resp_cnt = 0; resp_addr = 32'h0;
        model_reset();
        #2 rst = 1'b0;
        repeat (2) tick();
        chk("reset_valid", s_valid, 1'b0);
        chk("reset_instr", s_instr, 32'h0000_0000);
        chk("reset_pc4", s_pc4, 32'h0000_0004);
        chk("reset_req", s_req, 1'b0);
        rst = 1'b1;

        // Basic fetch, 1-cycle memory.
        tick();                                   // A
        chk("A_req", s_req, 1'b1); chk("A_we", s_we, 1'b1); chk("A_addr", s_addr, 32'h0);
        tick();                                   // B
        chk("B_valid", s_valid, 1'b0);
        tick();                                   // C
        chk("C_valid", s_valid, 1'b1); chk("C_pc", s_pc, 32'h0); chk("C_pc4", s_pc4, 32'h4);
        chk("C_instr", s_instr, 32'h2008_0005); chk("C_addr", s_addr, 32'h4);

        // Stall while the response lands: skid holds it.
        stall_id = 1'b1;
        tick();                                   // D
        tick();                                   // E
        chk("E_req", s_req, 1'b0); chk("E_we", s_we, 1'b0); chk("E_pc", s_pc, 32'h0);
        stall_id = 1'b0;
        tick();                                   // F
        chk("F_req", s_req, 1'b1); chk("F_we", s_we, 1'b1); chk("F_addr", s_addr, 32'h8);
        tick();                                   // G
        chk("G_valid", s_valid, 1'b1); chk("G_pc", s_pc, 32'h4); chk("G_instr", s_instr, 32'h2008_0001);

        // Flush in WAIT, response 3 cycles late.
        lat = 3;
        tick();                                   // H
        chk("H_addr", s_addr, 32'hC);
        flush = 1'b1; target = 32'h0040_0100;
        tick();                                   // I
        chk("I_we", s_we, 1'b1); chk("I_req", s_req, 1'b0);
        flush = 1'b0;
        tick();                                   // J
        chk("J_valid", s_valid, 1'b0); chk("J_instr", s_instr, 32'h0);
        tick();                                   // K
        tick();                                   // L
        chk("L_req", s_req, 1'b1); chk("L_addr", s_addr, 32'h0040_0100); chk("L_valid", s_valid, 1'b0);

        // Flush coincident with rvalid.
        repeat (2) tick();                        // M, N
        flush = 1'b1; target = 32'h0000_2000;
        tick();                                   // O
        chk("O_we", s_we, 1'b1); chk("O_req", s_req, 1'b0);
        flush = 1'b0; lat = 1;
        tick();                                   // P
        chk("P_addr", s_addr, 32'h0000_2000); chk("P_valid", s_valid, 1'b0);

        // Flush while stalled with the skid full.
        stall_id = 1'b1;
        tick();                                   // Q
        tick();                                   // R
        chk("R_req", s_req, 1'b0);
        flush = 1'b1; target = 32'h0000_3000;
        tick();                                   // S
        chk("S_we", s_we, 1'b1);
        flush = 1'b0; stall_id = 1'b0; lat = 2;
        tick();                                   // T
        chk("T_valid", s_valid, 1'b0); chk("T_instr", s_instr, 32'h0);
        chk("T_req", s_req, 1'b1); chk("T_addr", s_addr, 32'h0000_3000);

        // Reset mid-WAIT; the stale response arrives in ISSUE.
        rst = 1'b0;
        tick();                                   // U
        chk("U_valid", s_valid, 1'b0); chk("U_pc", s_pc, 32'h0); chk("U_pc4", s_pc4, 32'h4);
        chk("U_req", s_req, 1'b0); chk("U_we", s_we, 1'b0);
        rst = 1'b1;
        tick();                                   // V
        chk("V_req", s_req, 1'b1); chk("V_addr", s_addr, 32'h0);
        repeat (2) tick();                        // W, X
        tick();                                   // Y
        chk("Y_valid", s_valid, 1'b1); chk("Y_pc", s_pc, 32'h0); chk("Y_instr", s_instr, 32'h2008_0005);

        // Redirect to the top of the address space (pc[1:0] set, ignored).
        flush = 1'b1; target = 32'hFFFF_FFFE;
        tick();                                   // Z
        chk("Z_we", s_we, 1'b1);
        flush = 1'b0;
        tick();                                   // AA
        tick();                                   // AB
        chk("AB_addr", s_addr, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (s_valid) found = 1'b1;
        end
        chk("wrap_seen", found, 1'b1);
        chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", s_pc4, 32'h0000_0000);
        chk("wrap_instr", s_instr, 32'hDFF7_FFF9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
